mem_stage_port: RTL and testbench
=================================

# mem_stage_port

Multi-cycle data-memory port for the MEM stage of the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register and replaces the single-cycle data memory. It accepts one load or store per instruction and serves it from an internal word RAM with a fixed, parameterised access latency. While an access is in flight it raises `stall` so the hazard logic freezes PC, IF/ID, ID/EX and EX/MEM and bubbles MEM/WB.

## Interface
- `WORDS`, 256: RAM depth in 32-bit words; must be a power of two.
- `LATENCY`, 2: access latency in cycles; must be ≥ 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  load request, from EX/MEM (`Mem_MemRead`).
- `mem_write`  in  1  store request, from EX/MEM (`Mem_MemWrite`).
- `addr`  in  32  byte address (EX/MEM ALU result).
- `wdata`  in  32  store data (EX/MEM write data).
- `rdata`  out  32  load result, to MEM/WB.
- `stall`  out  1  pipeline freeze request (combinational).
- `err`  out  1  sticky flag: `mem_read` and `mem_write` were both high in one request.

## Operation
- Word index is `addr[log2(WORDS)+1:2]`. `addr[1:0]` and the bits above the index are ignored, so out-of-range addresses wrap modulo `WORDS`.
- FSM states:
  - IDLE: no request active. `stall = mem_read | mem_write`. On a request, latch `addr`, `wdata` and the op, load the counter with `LATENCY-1`, and go to BUSY.
  - BUSY: `stall = 1`. The counter decrements each cycle. When the counter is 0, commit the access and go to DONE.
  - DONE: `stall = 0`. `rdata` is valid. Inputs are ignored, because EX/MEM still shows the same request. The next state is always IDLE.
- Commit on the BUSY-to-DONE edge:
  - Store: `ram[idx] <= wdata_latched`.
  - Load: `rdata <= ram[idx]`.
- Both read and write high at request time:
  - Perform the write.
  - `rdata <= 0`.
  - `err` sets and stays at 1 until `rst`.
- `rdata` is updated only by a load commit or the error case. Otherwise it holds its value, including across stores.
- No op (both strobes low) in IDLE: no state change, `stall = 0`.

## Timing
- Reset values:
  - state = IDLE, counter = 0.
  - `rdata` = 0, `err` = 0, `stall` = 0.
  - All RAM words = 0; the RAM is cleared on `rst`.
- Request first visible in IDLE at cycle T:
  - `stall` is high in cycles T through T+LATENCY.
  - DONE is in cycle T+LATENCY+1, with `stall` low.
  - MEM/WB captures `rdata` at the end of cycle T+LATENCY+1.
  - Total MEM-stage occupancy is LATENCY+2 cycles.
- With LATENCY = 1, the commit edge is the end of cycle T+1 (one BUSY cycle).
- Back-to-back memory ops: the second request is seen in IDLE at T+LATENCY+2. There is no lost cycle beyond the DONE cycle.
- Reset mid-operation has priority over everything:
  - `rst` high in any cycle up to and including the last BUSY cycle aborts the access; no RAM write occurs.
  - `rst` high in the DONE cycle clears `rdata`.
- `stall` depends combinationally on `mem_read` and `mem_write` only in IDLE. There is no combinational path from `addr` or `wdata` to any output.

## Structure
- Shared pipeline package holds:
  - state enum `MEM_IDLE`, `MEM_BUSY`, `MEM_DONE` (2-bit);
  - `MEM_WORDS_DEFAULT = 256`;
  - `MEM_LATENCY_DEFAULT = 2`.
- One sub-module, `word_ram`:
  - synchronous-write, synchronous-read array with sync clear;
  - ports: clk, rst, we, re, idx, din, dout.
- The FSM, counter, latches and `err` live in `mem_stage_port`.
- The top-level pipeline ORs `stall` into the existing hazard stall/flush controls.

## Test plan
- Store then load, LATENCY = 2:
  - Stimulus: write `0xDEADBEEF` to address `0x10`, then read `0x10`.
  - `stall` is high for 3 cycles for each op; `rdata = 0xDEADBEEF` in the read's DONE cycle.
- Address wrap, WORDS = 256:
  - Stimulus: write `0x12345678` to `0x400`, then read `0x000`.
  - The read returns `0x12345678`. A read of `0x003` also returns it (low bits ignored).
- Idle and hold:
  - Stimulus: strobes low for 10 cycles after a load of `0xA5A5A5A5`.
  - `stall = 0` throughout; `rdata` holds `0xA5A5A5A5`; a later store leaves `rdata` unchanged.
- Simultaneous strobes:
  - Stimulus: `mem_read = mem_write = 1` with `wdata = 0x55` at `0x20`.
  - `rdata = 0` and `err = 1` from DONE onward; a subsequent read of `0x20` returns `0x55`; `err` stays set until `rst`.
- Reset mid-BUSY:
  - Stimulus: store `0xFFFFFFFF` to `0x08` with `rst` pulsed in the first BUSY cycle.
  - The next cycle is IDLE with `stall = 0`; a read of `0x08` returns 0.
- LATENCY = 1 and LATENCY = 5 builds:
  - `stall` width is exactly LATENCY+1 cycles per access.
  - Back-to-back loads complete every LATENCY+2 cycles.

Source files
------------

// File: rtl/mem_stage_port_pkg.sv
// Shared MEM-stage definitions: port FSM states and default geometry.
package mem_stage_port_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  localparam int MEM_WORDS_DEFAULT   = 256;
  localparam int MEM_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/mem_stage_port_word_ram.sv
// Word RAM with synchronous write, registered read and a synchronous clear.
module word_ram #(
  parameter int WORDS = 256,
  parameter int IDX_W = $clog2(WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic             re,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      din,
  output logic [31:0]      dout
);

  logic [31:0] mem [WORDS];

  // dout only moves on a read, so it doubles as the held load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WORDS; i++) mem[i] <= '0;
      dout <= '0;
    end else begin
      if (we) mem[idx] <= din;
      if (re) dout <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage_port.sv
// Multi-cycle MEM-stage data port: IDLE -> BUSY (LATENCY cycles) -> DONE, with
// a combinational stall for the hazard unit and a sticky read+write error flag.
module mem_stage_port
  import mem_stage_port_pkg::*;
#(
  parameter int WORDS   = MEM_WORDS_DEFAULT,
  parameter int LATENCY = MEM_LATENCY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic [1:0]  fsm_state
);

  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             rd_q;
  logic             wr_q;
  logic             zero_q;
  logic             commit;
  logic             we;
  logic             re;
  logic [31:0]      dout;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

  assign commit = (state == MEM_BUSY) && (cnt == '0);
  assign we     = commit & wr_q;
  assign re     = commit & rd_q & ~wr_q;

  assign stall     = (state == MEM_IDLE) ? (mem_read | mem_write) : (state == MEM_BUSY);
  assign rdata     = zero_q ? 32'd0 : dout;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MEM_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      zero_q  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (mem_read | mem_write) begin
            idx_q   <= addr[IDX_W+1:2];
            wdata_q <= wdata;
            rd_q    <= mem_read;
            wr_q    <= mem_write;
            cnt     <= CNT_W'(LATENCY - 1);
            state   <= MEM_BUSY;
          end
        end
        MEM_BUSY: begin
          if (cnt == '0) begin
            state <= MEM_DONE;
            // A conflicting request still writes, but reports zero data.
            if (rd_q & wr_q) begin
              err    <= 1'b1;
              zero_q <= 1'b1;
            end else if (rd_q) begin
              zero_q <= 1'b0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        MEM_DONE: state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  word_ram #(.WORDS(WORDS), .IDX_W(IDX_W)) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .re   (re),
    .idx  (idx_q),
    .din  (wdata_q),
    .dout (dout)
  );

endmodule

// File: tb/tb_mem_stage_port.sv
// Directed bench for mem_stage_port: a table of load/store records plus
// hand-written reset, idle-hold and latency-pattern sequences.
module tb_mem_stage_port;
  import mem_stage_port_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata1, rdata5;
  logic        stall, stall1, stall5;
  logic        err, err1, err5;
  logic [1:0]  fsm_state, fsm_state1, fsm_state5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_port #(.WORDS(256), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .err(err),
    .fsm_state(fsm_state)
  );

  mem_stage_port #(.WORDS(256), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata1), .stall(stall1), .err(err1),
    .fsm_state(fsm_state1)
  );

  mem_stage_port #(.WORDS(256), .LATENCY(5)) dut5 (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata5), .stall(stall5), .err(err5),
    .fsm_state(fsm_state5)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic        idle_after;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Samples on falling edges until stall drops, bounded at 20 cycles.
  task automatic wait_done(output int n, output logic [1:0] first_st);
    n = 0;
    @(negedge clk);
    first_st = fsm_state;
    while (stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (stall) begin
      errors++;
      $display("FAIL wait_done timeout stall still high after %0d cycles", n);
    end
  endtask

  task automatic run_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rdata,
                        input logic exp_err);
    int n;
    logic [1:0] st0;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
    wait_done(n, st0);
    chk("first_state_idle", {30'd0, st0}, {30'd0, MEM_IDLE});
    chk("stall_cycles", n, LAT + 1);
    chk("done_state", {30'd0, fsm_state}, {30'd0, MEM_DONE});
    chk("rdata_done", rdata, exp_rdata);
    chk("err_done", {31'd0, err}, {31'd0, exp_err});
  endtask

  task automatic drop_strobes();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    int n;
    logic [1:0] st0;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h000, 32'h0,        32'h12345678, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h003, 32'h0,        32'h12345678, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 32'h44,  32'hA5A5A5A5, 32'h12345678, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h44,  32'h0,        32'hA5A5A5A5, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 32'h48,  32'h00000001, 32'hA5A5A5A5, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 32'h20,  32'h00000055, 32'h0,        1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 32'h20,  32'h0,        32'h00000055, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h7FC, 32'h0,        32'h0,        1'b1, 1'b0};

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {30'd0, fsm_state}, {30'd0, MEM_IDLE});
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].exp_rdata, vecs[i].exp_err);
      if (vecs[i].idle_after) begin
        drop_strobes();
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          chk("idle_stall", {31'd0, stall}, 32'd0);
          chk("idle_rdata_hold", rdata, vecs[i].exp_rdata);
        end
      end
    end
    drop_strobes();
    @(negedge clk);
    chk("err_sticky", {31'd0, err}, 32'd1);

    // Reset in the first BUSY cycle of a store aborts it.
    @(posedge clk); #1;
    mem_write = 1'b1; addr = 32'h08; wdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    chk("abort_state", {30'd0, fsm_state}, {30'd0, MEM_IDLE});
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_err_cleared", {31'd0, err}, 32'd0);
    run_op(1'b1, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0);
    run_op(1'b1, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

    // Reset during DONE clears the load result.
    run_op(1'b0, 1'b1, 32'h08, 32'h7, 32'h0, 1'b0);
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; addr = 32'h08;
    wait_done(n, st0);
    chk("done_rst_pre", rdata, 32'h7);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    chk("done_rst_rdata", rdata, 32'h0);
    chk("done_rst_state", {30'd0, fsm_state}, {30'd0, MEM_IDLE});

    // Held load strobe: back-to-back loads on LATENCY 1, 2 and 5 ports.
    @(posedge clk); #1;
    mem_read = 1'b1; addr = 32'h0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      chk("b2b_stall_lat2", {31'd0, stall},  {31'd0, ((k % (LAT + 2)) != (LAT + 1))});
      chk("b2b_stall_lat1", {31'd0, stall1}, {31'd0, ((k % 3) != 2)});
      chk("b2b_stall_lat5", {31'd0, stall5}, {31'd0, ((k % 7) != 6)});
    end
    drop_strobes();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
